// File: rtl/estagio_mem.sv
// ============================================================================
// Module      : estagio_mem
// Description : Pipeline MEM stage: EX/MEM and MEM/WB registers, branch resolve,
//               word-addressed data memory and optional wait states (MEM_STALL_EN).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module estagio_mem #(
    parameter int ADDR_W   = 8,
    parameter int LATENCIA = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] saidaULA,
    input  logic [31:0] dado2ALU_out,
    input  logic [4:0]  RD,
    input  logic        zeroEx,
    input  logic [31:0] saidaSomador,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic        Branch_EX,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        flush,
    output logic [31:0] resultadoALU_MEM,
    output logic [4:0]  RD_MEM,
    output logic        RegWrite_MEM,
    output logic        PCSrc,
    output logic [31:0] alvoDesvio,
    output logic [4:0]  RD_WB,
    output logic        RegWrite_WB,
    output logic        MemtoReg_WB,
    output logic [31:0] dadoLido_WB,
    output logic [31:0] resultadoALU_WB,
    output logic [31:0] resultadoMux_WB,
    output logic        stall
);

    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_branch;
    logic              r_zero;
    logic              r_memtoreg;
    logic [31:0]       r_dado2;
    logic [31:0]       r_mem [2**ADDR_W];
    logic [ADDR_W-1:0] w_idx;
    logic [31:0]       w_rdata;

    // EX/MEM register; flush clears only the control bits
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resultadoALU_MEM <= '0;
            RD_MEM           <= '0;
            RegWrite_MEM     <= 1'b0;
            alvoDesvio       <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_branch         <= 1'b0;
            r_zero           <= 1'b0;
            r_memtoreg       <= 1'b0;
            r_dado2          <= '0;
        end else if (!stall) begin
            resultadoALU_MEM <= saidaULA;
            RD_MEM           <= RD;
            alvoDesvio       <= saidaSomador;
            r_zero           <= zeroEx;
            r_dado2          <= dado2ALU_out;
            RegWrite_MEM     <= RegWrite_EX & ~flush;
            r_mem_read       <= MemRead_EX  & ~flush;
            r_mem_write      <= MemWrite_EX & ~flush;
            r_branch         <= Branch_EX   & ~flush;
            r_memtoreg       <= MemtoReg_EX & ~flush;
        end
    end

    assign PCSrc = r_branch & r_zero;

    // Word index drops byte offset; upper address bits alias
    assign w_idx   = resultadoALU_MEM[ADDR_W+1:2];
    assign w_rdata = r_mem[w_idx];

    always_ff @(posedge clock) begin
        if (r_mem_write && !stall && !reset) begin
            r_mem[w_idx] <= r_dado2;
        end
    end

`ifdef MEM_STALL_EN
    // Wait-state counter: zero is OCIOSO, nonzero is ESPERA
    localparam int CONT_W = (LATENCIA > 0) ? $clog2(LATENCIA + 1) : 1;
    localparam logic [CONT_W-1:0] c_lat = CONT_W'(LATENCIA);

    logic [CONT_W-1:0] r_cont;
    logic [CONT_W-1:0] w_cont_next;

    assign stall = (r_mem_read | r_mem_write) & (r_cont < c_lat);

    always_comb begin
        w_cont_next = '0;
        if (stall) begin
            w_cont_next = r_cont + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cont <= '0;
        end else begin
            r_cont <= w_cont_next;
        end
    end
`else
    assign stall = 1'b0;
`endif

    // MEM/WB register; a stalled cycle presents a bubble to write-back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            RD_WB           <= '0;
            RegWrite_WB     <= 1'b0;
            MemtoReg_WB     <= 1'b0;
            dadoLido_WB     <= '0;
            resultadoALU_WB <= '0;
        end else if (stall) begin
            RegWrite_WB     <= 1'b0;
        end else begin
            RD_WB           <= RD_MEM;
            RegWrite_WB     <= RegWrite_MEM;
            MemtoReg_WB     <= r_memtoreg;
            dadoLido_WB     <= w_rdata;
            resultadoALU_WB <= resultadoALU_MEM;
        end
    end

    assign resultadoMux_WB = MemtoReg_WB ? dadoLido_WB : resultadoALU_WB;

endmodule

`default_nettype wire

// File: tb/tb_estagio_mem.sv
// ============================================================================
// Module      : tb_estagio_mem
// Description : Randomized scoreboard bench for estagio_mem (either MEM_STALL_EN build).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_estagio_mem;

    localparam int AW  = 8;
    localparam int LAT = 2;
`ifdef MEM_STALL_EN
    localparam int EXP_LAT = LAT;
`else
    localparam int EXP_LAT = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] saidaULA = '0, dado2ALU_out = '0, saidaSomador = '0;
    logic [4:0]  RD = '0;
    logic        zeroEx = 1'b0, MemRead_EX = 1'b0, MemWrite_EX = 1'b0;
    logic        Branch_EX = 1'b0, RegWrite_EX = 1'b0, MemtoReg_EX = 1'b0, flush = 1'b0;
    logic [31:0] resultadoALU_MEM, alvoDesvio, dadoLido_WB, resultadoALU_WB, resultadoMux_WB;
    logic [4:0]  RD_MEM, RD_WB;
    logic        RegWrite_MEM, PCSrc, RegWrite_WB, MemtoReg_WB, stall;

    estagio_mem #(.ADDR_W(AW), .LATENCIA(LAT)) dut (
        .clock(clock), .reset(reset),
        .saidaULA(saidaULA), .dado2ALU_out(dado2ALU_out), .RD(RD), .zeroEx(zeroEx),
        .saidaSomador(saidaSomador), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .Branch_EX(Branch_EX), .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
        .flush(flush), .resultadoALU_MEM(resultadoALU_MEM), .RD_MEM(RD_MEM),
        .RegWrite_MEM(RegWrite_MEM), .PCSrc(PCSrc), .alvoDesvio(alvoDesvio),
        .RD_WB(RD_WB), .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB),
        .dadoLido_WB(dadoLido_WB), .resultadoALU_WB(resultadoALU_WB),
        .resultadoMux_WB(resultadoMux_WB), .stall(stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] mux;
        logic [31:0] alu;
        logic        mtr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_mem [int];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % (1 << AW));
    endfunction

    // Monitor: every write-back the DUT presents must match the oldest expectation
    always @(negedge clock) begin
        if (!reset && RegWrite_WB) begin
            if (q.size() == 0) begin
                chk("wb_spurious", 32'(RegWrite_WB), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("wb_rd", 32'(RD_WB), 32'(e.rd));
                chk("wb_mux", resultadoMux_WB, e.mux);
                chk("wb_alu", resultadoALU_WB, e.alu);
                chk("wb_memtoreg", 32'(MemtoReg_WB), 32'(e.mtr));
            end
        end
    end

    task automatic bubble();
        MemRead_EX = 0; MemWrite_EX = 0; Branch_EX = 0; RegWrite_EX = 0; MemtoReg_EX = 0;
        flush = 0; RD = 5'($urandom); saidaULA = $urandom; dado2ALU_out = $urandom;
        saidaSomador = $urandom; zeroEx = 1'($urandom);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_alu_mem"}, resultadoALU_MEM, 0);
        chk({tag, "_alvo"}, alvoDesvio, 0);
        chk({tag, "_ctl_mem"}, {25'd0, RD_MEM, RegWrite_MEM, PCSrc}, 0);
        chk({tag, "_ctl_wb"}, {24'd0, RD_WB, RegWrite_WB, MemtoReg_WB, stall}, 0);
        chk({tag, "_dado_wb"}, dadoLido_WB, 0);
        chk({tag, "_alu_wb"}, resultadoALU_WB, 0);
        chk({tag, "_mux_wb"}, resultadoMux_WB, 0);
    endtask

    // kind: 0 = ALU op, 1 = load, 2 = store
    task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic br, input logic z,
                         input logic [31:0] tgt, input logic fl);
        logic rw;
        logic memop;
        exp_t e;
        int   n;
        rw    = (kind != 2);
        memop = (kind != 0) && !fl;
        saidaULA = a; dado2ALU_out = d; RD = rd; zeroEx = z; saidaSomador = tgt;
        MemRead_EX = (kind == 1); MemWrite_EX = (kind == 2); Branch_EX = br;
        RegWrite_EX = rw; MemtoReg_EX = (kind == 1); flush = fl;
        if (!fl) begin
            if (kind == 2) begin
                model_mem[widx(a)] = d;
            end else begin
                e.rd  = rd;
                e.alu = a;
                e.mtr = (kind == 1);
                e.mux = (kind == 1) ? model_mem[widx(a)] : a;
                q.push_back(e);
            end
        end
        @(posedge clock); #1;
        chk("mem_rd", 32'(RD_MEM), 32'(rd));
        chk("mem_alu", resultadoALU_MEM, a);
        chk("mem_regwrite", 32'(RegWrite_MEM), 32'(rw & !fl));
        chk("pcsrc", 32'(PCSrc), 32'(br & z & !fl));
        chk("alvo", alvoDesvio, tgt);
        bubble();
        n = 0;
        while (stall && n < 20) begin
            chk("hold_rd", 32'(RD_MEM), 32'(rd));
            @(posedge clock); #1;
            n++;
        end
        chk("stall_cycles", 32'(n), memop ? 32'(EXP_LAT) : 32'd0);
        @(posedge clock); #1;
    endtask

    function automatic logic [31:0] rand_addr(input int idx);
        logic [31:0] a;
        a = $urandom;
        a[9:2] = 8'(idx);
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_zero("reset_state");
        reset = 0;

        for (int i = 0; i < 16; i++) do_op(2, rand_addr(i), $urandom, 0, 0, 0, 0, 0);

        do_op(2, 32'h10, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0, 0);
        do_op(1, 32'h10, 32'h0, 5'd5, 0, 0, 32'h0, 0);

        do_op(0, $urandom, 0, 5'd9, 1, 1, 32'h40, 0);
        do_op(0, $urandom, 0, 5'd9, 1, 0, 32'h40, 0);

        do_op(2, 32'h0C, 32'hCAFEF00D, 5'd0, 1, 1, 32'h80, 1);
        do_op(0, 32'h0C, 32'h0, 5'd3, 0, 0, 32'h0, 1);
        do_op(1, 32'h0C, 32'h0, 5'd3, 0, 0, 32'h0, 0);

        do_op(2, 32'h400, 32'h1234, 5'd0, 0, 0, 32'h0, 0);
        do_op(1, 32'h000, 32'h0, 5'd7, 0, 0, 32'h0, 0);

        // Asynchronous reset between edges with an op sitting in MEM
        saidaULA = 32'h55AA; RD = 5'd11; RegWrite_EX = 1; Branch_EX = 1; zeroEx = 1;
        saidaSomador = 32'h99;
        @(posedge clock); #1;
        bubble();
        #1 reset = 1;
        #1 check_zero("reset_mid");
        #1 reset = 0;
        @(posedge clock); #1;

`ifdef MEM_STALL_EN
        // Reset during the second wait cycle abandons the store
        saidaULA = 32'h1C; dado2ALU_out = 32'hBAD0BAD0; MemWrite_EX = 1; RD = 0;
        @(posedge clock); #1;
        bubble();
        chk("wait_stall_c1", 32'(stall), 32'd1);
        @(posedge clock); #1;
        chk("wait_stall_c2", 32'(stall), 32'd1);
        reset = 1;
        #1 chk("reset_wait_stall", 32'(stall), 32'd0);
        check_zero("reset_wait");
        #1 reset = 0;
        @(posedge clock); #1;
        do_op(1, 32'h1C, 32'h0, 5'd8, 0, 0, 32'h0, 0);
`endif

        for (int i = 0; i < 60; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            if (kind == 0)
                do_op(0, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 5) == 0));
            else
                do_op(kind, rand_addr(int'($urandom_range(0, 15))), $urandom, 5'($urandom),
                      1'($urandom), 1'($urandom), $urandom, 1'($urandom_range(0, 5) == 0));
        end

        repeat (4) @(posedge clock);
        #1 chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/estagio_mem.md
# estagio_mem

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. It holds the EX/MEM pipeline register and resolves branches from the registered zero flag. It contains the word-addressed data memory and the MEM/WB pipeline register. It also drives the two forwarding sources, `resultadoALU_MEM` and `resultadoMux_WB`, that feed back into the execute stage's forwarding muxes.

## Interface
Parameters:
- `ADDR_W`, 8: word-address width; data memory holds 2^ADDR_W 32-bit words.
- `LATENCIA`, 2: wait cycles per load/store; used only when `MEM_STALL_EN` is defined.

Ports:
- `clock`  in  1  single clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `saidaULA`  in  32  EX ALU result, used as address or as pass-through result.
- `dado2ALU_out`  in  32  EX store data.
- `RD`  in  5  EX destination register.
- `zeroEx`  in  1  EX ALU zero flag.
- `saidaSomador`  in  32  EX branch target.
- `MemRead_EX`, `MemWrite_EX`, `Branch_EX`, `RegWrite_EX`, `MemtoReg_EX`  in  1 each  EX control bits.
- `flush`  in  1  loads a bubble into EX/MEM.
- `resultadoALU_MEM`  out  32  registered ALU result; forwarding source.
- `RD_MEM`  out  5  registered destination register.
- `RegWrite_MEM`  out  1  registered write enable.
- `PCSrc`  out  1  branch taken.
- `alvoDesvio`  out  32  registered branch target.
- `RD_WB`  out  5  MEM/WB destination register.
- `RegWrite_WB`  out  1  MEM/WB write enable.
- `MemtoReg_WB`  out  1  MEM/WB write-back select.
- `dadoLido_WB`  out  32  MEM/WB load data.
- `resultadoALU_WB`  out  32  MEM/WB ALU result.
- `resultadoMux_WB`  out  32  write-back value; forwarding source.
- `stall`  out  1  upstream stages must hold.

## Operation
EX/MEM register:
- Captures all EX inputs each edge while `stall`=0.
- `flush`=1 (with `stall`=0) clears the control bits `MemRead`, `MemWrite`, `Branch`, `RegWrite` and `MemtoReg`. The data fields still load.
- `stall`=1 holds EX/MEM contents; `stall` has priority over `flush`.

Branch:
- `PCSrc` = `Branch_MEM` & `zero_MEM`, combinational from the EX/MEM register.
- `alvoDesvio` is the registered `saidaSomador`.

Data memory:
- Word index = `resultadoALU_MEM[ADDR_W+1:2]`. Upper bits are ignored, so addresses alias modulo 2^ADDR_W words.
- Byte offset bits [1:0] are ignored.
- The array is not cleared by `reset`; its contents are undefined until written.
- A store commits at the edge that completes the access.
- A load reads the array combinationally and is captured into `dadoLido_WB` at the completing edge.
- If a load follows a store to the same word, the load returns the newly stored value.

MEM/WB register:
- On a completing edge it captures `RD_MEM`, `RegWrite_MEM`, `MemtoReg_MEM`, `resultadoALU_MEM` and the read data.
- While `stall`=1 it loads a bubble: `RegWrite_WB`=0.
- `resultadoMux_WB` = `MemtoReg_WB` ? `dadoLido_WB` : `resultadoALU_WB`.

Wait-state counter `cont` (width ceil(log2(LATENCIA+1))):
- States: OCIOSO (`cont`=0) and ESPERA (`cont`>0).
- `stall` = (`MemRead_MEM` | `MemWrite_MEM`) & (`cont` < `LATENCIA`).
- On an edge with `stall`=1: `cont`++.
- On an edge with `stall`=0: `cont` ← 0, the access completes, and the pipeline advances.
- A memory op therefore occupies MEM for `LATENCIA`+1 cycles. Non-memory ops never stall.

## Timing
- `reset`=1 asynchronously clears every output to 0: all EX/MEM fields, all MEM/WB fields, `cont`, `PCSrc` and `stall`.
- Reset asserted mid-ESPERA abandons the access. No store commits.
- Latency without waits: an instruction present at EX at edge N appears on the `_MEM` outputs after edge N and on the `_WB` outputs after edge N+1.
- With waits, the `_WB` outputs of a memory op appear after edge N+1+`LATENCIA`.
- `stall` and `PCSrc` are combinational from registered state only; there are no combinational paths from inputs to outputs.
- `LATENCIA`=0 never asserts `stall`.

## Configuration
- `MEM_STALL_EN` defined: the wait-state counter and the `stall` logic are built as described, using `LATENCIA`.
- `MEM_STALL_EN` undefined:
  - `stall` is tied to 0 and `cont` is removed.
  - Every access completes in one cycle.
  - `LATENCIA` is ignored.

## Test plan
- Reset: raise `reset` mid-stream between edges -> all outputs read 0 immediately, before the next edge.
- Store/load: sw `0xDEADBEEF` at address `0x10`, then lw `0x10` with `RD`=5, `MemtoReg`=1 (macro off) -> one edge after lw leaves MEM: `resultadoMux_WB`=`0xDEADBEEF`, `RD_WB`=5, `RegWrite_WB`=1.
- Branch: `Branch_EX`=1, `zeroEx`=1, `saidaSomador`=`0x40` -> after the edge `PCSrc`=1 and `alvoDesvio`=`0x40`. Repeat with `zeroEx`=0 -> `PCSrc`=0.
- Flush: `flush`=1 with `MemWrite_EX`=1 and `RegWrite_EX`=1 -> `RegWrite_MEM`=0 and memory unchanged on readback.
- Wait states: `MEM_STALL_EN` on, `LATENCIA`=2, lw issued:
  - `stall` is high for exactly 2 cycles and EX/MEM holds;
  - `RegWrite_WB`=0 during the stall;
  - load data appears on the third edge.
  - Reset asserted in the second wait cycle -> `stall`=0 and `cont`=0.
- Aliasing: `ADDR_W`=8, sw `0x1234` at address `0x400`, lw address `0x000` -> returns `0x1234`.
